univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter: RST_VAL, default {WIDTH{1'b0}}, value loaded into q on reset and on clear.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 Port: en  input  1  clock enable; when low, all state holds (sync_clr excepted).
REQ-006 Port: sync_clr  input  1  synchronous clear; independent of en.
REQ-007 Port: mode  input  3  operation select (see Function).
REQ-008 Port: d  input  WIDTH  parallel load data.
REQ-009 Port: si_l  input  1  serial input entering bit 0 on shift-left.
REQ-010 Port: si_r  input  1  serial input entering bit WIDTH-1 on shift-right.
REQ-011 Port: q  output  WIDTH  registered contents.
REQ-012 Port: cnt  output  $clog2(WIDTH+1)  shifts performed since last load/clear, saturating at WIDTH.
REQ-013 Port: drained  output  1  registered; high when cnt == WIDTH.

Function
REQ-014 All updates SHALL occur on rising clk only; latency from input to q is one cycle; no combinational path from inputs to outputs.
REQ-015 Priority SHALL be: rst_n low > sync_clr high > en low (hold) > mode decode.
REQ-016 sync_clr high SHALL set q = RST_VAL, cnt = 0, drained = 0 on the next edge regardless of en and mode.
REQ-017 mode 000 HOLD: q, cnt unchanged.
REQ-018 mode 001 LOAD: q <= d; cnt <= 0.
REQ-019 mode 010 SHL: q <= {q[WIDTH-2:0], si_l}; cnt increments.
REQ-020 mode 011 SHR: q <= {si_r, q[WIDTH-1:1]}; cnt increments.
REQ-021 mode 100 ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; cnt unchanged.
REQ-022 mode 101 ROTR: q <= {q[0], q[WIDTH-1:1]}; cnt unchanged.
REQ-023 mode 110 ASHR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; cnt increments.
REQ-024 mode 111 CLR: identical effect to sync_clr, but gated by en.
REQ-025 cnt increment SHALL saturate at WIDTH; further shifts leave cnt = WIDTH, no wrap to 0.
REQ-026 drained SHALL be registered and equal (cnt_next == WIDTH), so drained and cnt change on the same edge.
REQ-027 Shift while drained SHALL still shift q; only cnt saturates.
REQ-028 LOAD on the same edge as drained high SHALL clear cnt and drained.
REQ-029 en low with any mode SHALL hold q, cnt, drained unchanged.
REQ-030 Block SHALL contain no latches; every register SHALL have a defined value in every branch.

Reset
REQ-031 rst_n low SHALL immediately, without a clock edge, force q = RST_VAL, cnt = 0, drained = 0.
REQ-032 Reset asserted mid-shift sequence SHALL abort it; after release the block behaves as freshly loaded with RST_VAL, cnt = 0.
REQ-033 First state update after rst_n release SHALL occur on the first rising clk with rst_n high.

Verification
REQ-034 WIDTH=8: rst_n low mid-cycle -> q=0x00, cnt=0, drained=0 before the next edge.
REQ-035 LOAD d=0xA5, then 8x SHL with si_l=0 -> q=0x00, cnt steps 1..8, drained=1 on the 8th edge; 9th SHL -> cnt stays 8.
REQ-036 LOAD 0x81, ROTL x1 -> q=0x03, cnt=0; ROTR x1 -> q=0x81.
REQ-037 LOAD 0x80, ASHR x3 -> q=0xF0, cnt=3; SHR with si_r=1 x1 from 0x01 -> q=0x80.
REQ-038 en=0 with mode=SHL for 5 cycles -> q, cnt unchanged; sync_clr=1 with en=0 -> q=RST_VAL, cnt=0.
REQ-039 Drained (cnt=8) with LOAD d=0x3C -> q=0x3C, cnt=0, drained=0 on the same edge.

Source files
------------

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg
// Brief    : Universal shift register (load/shift/rotate/arith-shift) with a
//            saturating shift counter and registered drained flag.
// Revision : 1.0 - initial release
// ============================================================================
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         sync_clr,
  input  logic [2:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  input  logic                         si_l,
  input  logic                         si_r,
  output logic [WIDTH-1:0]             q,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         drained
);

  localparam int c_cnt_w = $clog2(WIDTH+1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(WIDTH);

  localparam logic [2:0] c_mode_hold = 3'b000;
  localparam logic [2:0] c_mode_load = 3'b001;
  localparam logic [2:0] c_mode_shl  = 3'b010;
  localparam logic [2:0] c_mode_shr  = 3'b011;
  localparam logic [2:0] c_mode_rotl = 3'b100;
  localparam logic [2:0] c_mode_rotr = 3'b101;
  localparam logic [2:0] c_mode_ashr = 3'b110;
  localparam logic [2:0] c_mode_clr  = 3'b111;

  logic [WIDTH-1:0]   r_q;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_drained;

  logic [WIDTH-1:0]   w_q_next;
  logic [c_cnt_w-1:0] w_cnt_next;
  logic [c_cnt_w-1:0] w_cnt_sat;
  logic               w_drained_next;

  // Shift count stops at WIDTH instead of wrapping.
  assign w_cnt_sat = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_q_next   = r_q;
    w_cnt_next = r_cnt;
    if (sync_clr) begin
      w_q_next   = RST_VAL;
      w_cnt_next = '0;
    end else if (en) begin
      case (mode)
        c_mode_load: begin
          w_q_next   = d;
          w_cnt_next = '0;
        end
        c_mode_shl: begin
          w_q_next   = {r_q[WIDTH-2:0], si_l};
          w_cnt_next = w_cnt_sat;
        end
        c_mode_shr: begin
          w_q_next   = {si_r, r_q[WIDTH-1:1]};
          w_cnt_next = w_cnt_sat;
        end
        c_mode_rotl: w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        c_mode_rotr: w_q_next = {r_q[0], r_q[WIDTH-1:1]};
        c_mode_ashr: begin
          w_q_next   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
          w_cnt_next = w_cnt_sat;
        end
        c_mode_clr: begin
          w_q_next   = RST_VAL;
          w_cnt_next = '0;
        end
        c_mode_hold: begin
          w_q_next   = r_q;
          w_cnt_next = r_cnt;
        end
        default: begin
          w_q_next   = r_q;
          w_cnt_next = r_cnt;
        end
      endcase
    end
  end

  // Derived from the next count so drained moves on the same edge as cnt.
  assign w_drained_next = (w_cnt_next == c_cnt_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= RST_VAL;
      r_cnt     <= '0;
      r_drained <= 1'b0;
    end else begin
      r_q       <= w_q_next;
      r_cnt     <= w_cnt_next;
      r_drained <= w_drained_next;
    end
  end

  assign q       = r_q;
  assign cnt     = r_cnt;
  assign drained = r_drained;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_univ_shift_reg
// Brief    : Directed and random checks of univ_shift_reg against a
//            behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         sync_clr;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         si_l;
  logic         si_r;
  logic [W-1:0] q;
  logic [3:0]   cnt;
  logic         drained;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] m_q;
  int           m_cnt;

  univ_shift_reg #(.WIDTH(W), .RST_VAL(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (sync_clr),
    .mode     (mode),
    .d        (d),
    .si_l     (si_l),
    .si_r     (si_r),
    .q        (q),
    .cnt      (cnt),
    .drained  (drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_q   = 8'h00;
    m_cnt = 0;
  endtask

  // Reference behaviour expressed as plain arithmetic on the register value.
  task automatic model_step(input logic e, input logic c, input logic [2:0] m,
                            input logic [W-1:0] dd, input logic sl, input logic sr);
    logic [W-1:0] t_l;
    logic [W-1:0] t_r;
    t_l = {7'b0, sl};
    t_r = {sr, 7'b0};
    if (c) begin
      model_reset();
    end else if (e) begin
      case (m)
        3'd1: begin m_q = dd; m_cnt = 0; end
        3'd2: begin m_q = (m_q << 1) | t_l; m_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1; end
        3'd3: begin m_q = (m_q >> 1) | t_r; m_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1; end
        3'd4: m_q = (m_q << 1) | (m_q >> (W-1));
        3'd5: m_q = (m_q >> 1) | (m_q << (W-1));
        3'd6: begin m_q = W'($signed(m_q) >>> 1); m_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1; end
        3'd7: model_reset();
        default: ;
      endcase
    end
  endtask

  task automatic check(input string tag);
    checks++;
    assert (q === m_q) else begin
      failures++;
      $error("FAIL %s q actual=%h expected=%h", tag, q, m_q);
    end
    checks++;
    assert (cnt === 4'(m_cnt)) else begin
      failures++;
      $error("FAIL %s cnt actual=%0d expected=%0d", tag, cnt, m_cnt);
    end
    checks++;
    assert (drained === (m_cnt == W)) else begin
      failures++;
      $error("FAIL %s drained actual=%b expected=%b", tag, drained, (m_cnt == W));
    end
  endtask

  task automatic check_q(input string tag, input logic [W-1:0] exp_q, input int exp_cnt);
    checks++;
    assert (q === exp_q && cnt === 4'(exp_cnt)) else begin
      failures++;
      $error("FAIL %s q/cnt actual=%h/%0d expected=%h/%0d", tag, q, cnt, exp_q, exp_cnt);
    end
  endtask

  task automatic step(input logic e, input logic c, input logic [2:0] m,
                      input logic [W-1:0] dd, input logic sl, input logic sr,
                      input string tag);
    en = e; sync_clr = c; mode = m; d = dd; si_l = sl; si_r = sr;
    model_step(e, c, m, dd, sl, sr);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; mode = 3'd0;
    d = '0; si_l = 1'b0; si_r = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset");
    rst_n = 1'b1;

    // Fill then drain with zeros; count must stop at WIDTH.
    step(1, 0, 3'd1, 8'hA5, 0, 0, "load_a5");
    for (int i = 0; i < 8; i++) step(1, 0, 3'd2, 8'h00, 0, 0, "shl_drain");
    check_q("drain_done", 8'h00, 8);
    step(1, 0, 3'd2, 8'h00, 0, 0, "shl_sat");
    check_q("cnt_sat", 8'h00, 8);

    step(1, 0, 3'd1, 8'h3C, 0, 0, "load_while_drained");
    check_q("load_drained", 8'h3C, 0);

    step(1, 0, 3'd1, 8'h81, 0, 0, "load_81");
    step(1, 0, 3'd4, 8'h00, 0, 0, "rotl");
    check_q("rotl_val", 8'h03, 0);
    step(1, 0, 3'd5, 8'h00, 0, 0, "rotr");
    check_q("rotr_val", 8'h81, 0);

    step(1, 0, 3'd1, 8'h80, 0, 0, "load_80");
    for (int i = 0; i < 3; i++) step(1, 0, 3'd6, 8'h00, 0, 0, "ashr");
    check_q("ashr_val", 8'hF0, 3);
    step(1, 0, 3'd1, 8'h01, 0, 0, "load_01");
    step(1, 0, 3'd3, 8'h00, 0, 1, "shr_si1");
    check_q("shr_val", 8'h80, 1);

    for (int i = 0; i < 5; i++) step(0, 0, 3'd2, 8'h00, 1, 0, "en_low_hold");
    check_q("hold_val", 8'h80, 1);
    step(0, 1, 3'd2, 8'hFF, 1, 1, "sync_clr_en0");
    step(1, 0, 3'd1, 8'h77, 0, 0, "load_77");
    step(0, 0, 3'd7, 8'h00, 0, 0, "clr_mode_en0");
    step(1, 0, 3'd7, 8'h00, 0, 0, "clr_mode_en1");

    // Asynchronous reset mid-sequence, checked before any clock edge.
    step(1, 0, 3'd1, 8'h5A, 0, 0, "load_5a");
    step(1, 0, 3'd2, 8'h00, 1, 0, "shl_pre_rst");
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst");
    @(posedge clk);
    #1;
    check("rst_held");
    rst_n = 1'b1;
    step(1, 0, 3'd2, 8'h00, 1, 0, "first_after_rst");
    check_q("after_rst_val", 8'h01, 1);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
           3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom),
           "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
